// File: rtl/mdu_pkg.sv
// Shared types, op codes and class helpers for the MDU sequencer.
// Op codes follow the alpha pipe's 6-bit ALU op encoding.
package mdu_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} mdu_state_t;

    typedef enum logic [2:0] {NONE, MULS, MULU, DIVS, DIVU, MTHI, MTLO} op_class_t;

    typedef enum logic [1:0] {SET, ADD, SUB, GPR} acc_t;

    localparam logic [5:0] OP_MTHI  = 6'h11;
    localparam logic [5:0] OP_MTLO  = 6'h13;
    localparam logic [5:0] OP_MULT  = 6'h18;
    localparam logic [5:0] OP_MULTU = 6'h19;
    localparam logic [5:0] OP_DIV   = 6'h1A;
    localparam logic [5:0] OP_DIVU  = 6'h1B;
    localparam logic [5:0] OP_MADD  = 6'h1C;
    localparam logic [5:0] OP_MADDU = 6'h1D;
    localparam logic [5:0] OP_MSUB  = 6'h1E;
    localparam logic [5:0] OP_MSUBU = 6'h1F;
    localparam logic [5:0] OP_MUL   = 6'h20;

    function automatic logic is_mdu(op_class_t c);
        return (c == MULS) || (c == MULU) || (c == DIVS) || (c == DIVU);
    endfunction

    function automatic logic is_div(op_class_t c);
        return (c == DIVS) || (c == DIVU);
    endfunction

    // Unit start encoding: 10 signed, 01 unsigned.
    function automatic logic [1:0] unit_op(op_class_t c);
        return ((c == MULS) || (c == DIVS)) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Bus between the sequencer and the shared multiplier/divider units.
// Start is a one-cycle nonzero op; done is a level that is low while the unit is busy.
interface mdu_if;
    logic [1:0]  mult_op_o;
    logic [1:0]  div_op_o;
    logic [31:0] unit_a_o;
    logic [31:0] unit_b_o;
    logic        mult_done_i;
    logic        div_done_i;
    logic [63:0] mult_res_i;
    logic [63:0] div_res_i;

    modport master (
        output mult_op_o, div_op_o, unit_a_o, unit_b_o,
        input  mult_done_i, div_done_i, mult_res_i, div_res_i
    );

    modport slave (
        input  mult_op_o, div_op_o, unit_a_o, unit_b_o,
        output mult_done_i, div_done_i, mult_res_i, div_res_i
    );
endinterface

// File: rtl/mdu_op_decode.sv
// Combinational ALU op -> MDU op class and HI/LO accumulate mode.
module mdu_op_decode
    import mdu_pkg::*;
(
    input  logic [5:0] op_i,
    output op_class_t  class_o,
    output acc_t       acc_o
);

    always_comb begin
        class_o = NONE;
        acc_o   = SET;
        case (op_i)
            OP_MULT:  begin class_o = MULS; acc_o = SET; end
            OP_MULTU: begin class_o = MULU; acc_o = SET; end
            OP_MADD:  begin class_o = MULS; acc_o = ADD; end
            OP_MADDU: begin class_o = MULU; acc_o = ADD; end
            OP_MSUB:  begin class_o = MULS; acc_o = SUB; end
            OP_MSUBU: begin class_o = MULU; acc_o = SUB; end
            OP_MUL:   begin class_o = MULS; acc_o = GPR; end
            OP_DIV:   begin class_o = DIVS; acc_o = SET; end
            OP_DIVU:  begin class_o = DIVU; acc_o = SET; end
            OP_MTHI:  class_o = MTHI;
            OP_MTLO:  class_o = MTLO;
            default:  ;
        endcase
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Launches MDU ops on the shared mult/div units, stalls EX until commit, and owns HI/LO.
// Unit handshake: start is a registered one-cycle op pulse; completion is the rising edge of done.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int          TIMEOUT    = 64,
    parameter logic [63:0] HILO_RESET = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        req_valid,
    input  logic [5:0]  req_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        hilo_read_i,
    output logic        stall_o,
    output logic [63:0] hilo_o,
    output logic [31:0] result_o,
    output logic        result_valid_o,
    output logic        err_o,
    output mdu_state_t  state_o,
    mdu_if.master       unit
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    mdu_state_t  state_q, state_d;
    op_class_t   cls_q, cls_d, req_class;
    acc_t        acc_q, acc_d, req_acc;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0] hilo_q, hilo_d;
    logic        err_q, err_d;
    logic [1:0]  mult_op_q, mult_op_d, div_op_q, div_op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic        mdone_prev_q, ddone_prev_q;

    logic        sel_div, done_edge, commit, timeout, launch_ok;
    logic [63:0] unit_res;

    mdu_op_decode u_dec (
        .op_i    (req_op),
        .class_o (req_class),
        .acc_o   (req_acc)
    );

    assign sel_div   = is_div(cls_q);
    assign done_edge = sel_div ? (unit.div_done_i & ~ddone_prev_q)
                               : (unit.mult_done_i & ~mdone_prev_q);
    assign unit_res  = sel_div ? unit.div_res_i : unit.mult_res_i;
    assign launch_ok = is_div(req_class) ? unit.div_done_i : unit.mult_done_i;
    assign commit    = (state_q == BUSY) & done_edge & ~flush_i;
    assign timeout   = (cnt_q == CW'(TIMEOUT - 1)) & ~done_edge;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cls_d     = cls_q;
        acc_d     = acc_q;
        hilo_d    = hilo_q;
        err_d     = err_q;
        mult_op_d = 2'b00;
        div_op_d  = 2'b00;
        a_d       = a_q;
        b_d       = b_q;
        case (state_q)
            IDLE: begin
                if (req_valid && !flush_i) begin
                    if (req_class == MTHI) begin
                        hilo_d[63:32] = src_a;
                    end else if (req_class == MTLO) begin
                        hilo_d[31:0] = src_a;
                    end else if (is_mdu(req_class) && launch_ok) begin
                        if (is_div(req_class)) div_op_d  = unit_op(req_class);
                        else                   mult_op_d = unit_op(req_class);
                        a_d     = src_a;
                        b_d     = src_b;
                        cls_d   = req_class;
                        acc_d   = req_acc;
                        cnt_d   = '0;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CW'(1);
                if (flush_i) begin
                    // A done edge coinciding with the flush already finished the unit.
                    state_d = done_edge ? IDLE : DRAIN;
                end else if (done_edge) begin
                    state_d = IDLE;
                    case (acc_q)
                        SET:     hilo_d = unit_res;
                        ADD:     hilo_d = hilo_q + unit_res;
                        SUB:     hilo_d = hilo_q - unit_res;
                        default: ;
                    endcase
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                cnt_d = cnt_q + CW'(1);
                if (done_edge) begin
                    state_d = IDLE;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            cls_q        <= NONE;
            acc_q        <= SET;
            hilo_q       <= HILO_RESET;
            err_q        <= 1'b0;
            mult_op_q    <= 2'b00;
            div_op_q     <= 2'b00;
            a_q          <= '0;
            b_q          <= '0;
            mdone_prev_q <= 1'b1;
            ddone_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cls_q        <= cls_d;
            acc_q        <= acc_d;
            hilo_q       <= hilo_d;
            err_q        <= err_d;
            mult_op_q    <= mult_op_d;
            div_op_q     <= div_op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            mdone_prev_q <= unit.mult_done_i;
            ddone_prev_q <= unit.div_done_i;
        end
    end

    assign stall_o = ~flush_i & ((req_valid & is_mdu(req_class) & ~commit)
                               | (hilo_read_i & (state_q != IDLE)));
    assign result_valid_o = commit & (acc_q == GPR);
    assign result_o       = result_valid_o ? unit.mult_res_i[31:0] : 32'h0;
    assign hilo_o         = hilo_q;
    assign err_o          = err_q;
    assign state_o        = state_q;
    assign unit.mult_op_o = mult_op_q;
    assign unit.div_op_o  = div_op_q;
    assign unit.unit_a_o  = a_q;
    assign unit.unit_b_o  = b_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer with behavioural multiplier/divider unit models.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i, req_valid, hilo_read_i;
  logic [5:0]  req_op;
  logic [31:0] src_a, src_b;
  logic        stall_o, result_valid_o, err_o;
  logic [63:0] hilo_o;
  logic [31:0] result_o;
  mdu_state_t  state_o;

  int checks = 0;
  int failures = 0;
  int m_lat = 3, d_lat = 3;
  int m_cnt, d_cnt;
  int stalls, n;
  logic        rv;
  logic [31:0] res;

  always #5 clk = ~clk;

  mdu_if u_if ();

  mdu_sequencer #(.TIMEOUT(64), .HILO_RESET(64'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush_i),
    .req_valid      (req_valid),
    .req_op         (req_op),
    .src_a          (src_a),
    .src_b          (src_b),
    .hilo_read_i    (hilo_read_i),
    .stall_o        (stall_o),
    .hilo_o         (hilo_o),
    .result_o       (result_o),
    .result_valid_o (result_valid_o),
    .err_o          (err_o),
    .state_o        (state_o),
    .unit           (u_if.master)
  );

  function automatic logic [63:0] mul_model(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    if (op == 2'b10) return 64'(sa * sb);
    return {32'h0, a} * {32'h0, b};
  endfunction

  function automatic logic [63:0] div_model(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    if (op == 2'b10) return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
    return {a % b, a / b};
  endfunction

  // Unit models: done drops the cycle after start and rises after *_lat busy cycles.
  always @(posedge clk) begin
    if (rst) begin
      u_if.mult_done_i <= 1'b1;
      u_if.mult_res_i  <= 64'h0;
      m_cnt <= 0;
    end else if (u_if.mult_op_o != 2'b00) begin
      u_if.mult_done_i <= 1'b0;
      u_if.mult_res_i  <= mul_model(u_if.mult_op_o, u_if.unit_a_o, u_if.unit_b_o);
      m_cnt <= m_lat;
    end else if (!u_if.mult_done_i) begin
      if (m_cnt <= 1) u_if.mult_done_i <= 1'b1;
      else m_cnt <= m_cnt - 1;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      u_if.div_done_i <= 1'b1;
      u_if.div_res_i  <= 64'h0;
      d_cnt <= 0;
    end else if (u_if.div_op_o != 2'b00) begin
      u_if.div_done_i <= 1'b0;
      u_if.div_res_i  <= div_model(u_if.div_op_o, u_if.unit_a_o, u_if.unit_b_o);
      d_cnt <= d_lat;
    end else if (!u_if.div_done_i) begin
      if (d_cnt <= 1) u_if.div_done_i <= 1'b1;
      else d_cnt <= d_cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Holds the request in EX until stall_o drops; returns stall cycles and the commit-cycle result.
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int st, output logic v, output logic [31:0] r);
    req_valid = 1'b1;
    req_op = op;
    src_a = a;
    src_b = b;
    st = 0;
    v = 1'b0;
    r = 32'h0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (!stall_o) begin
        v = result_valid_o;
        r = result_o;
        break;
      end
      st++;
      tick();
    end
    tick();
    req_valid = 1'b0;
    req_op = 6'h0;
  endtask

  initial begin
    rst = 1'b1;
    flush_i = 1'b0;
    req_valid = 1'b0;
    hilo_read_i = 1'b0;
    req_op = 6'h0;
    src_a = 32'h0;
    src_b = 32'h0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("rst_state", 64'(state_o), 64'(IDLE));
    check("rst_hilo", hilo_o, 64'h0);
    check("rst_stall", 64'(stall_o), 64'h0);
    check("rst_err", 64'(err_o), 64'h0);
    check("rst_rv", 64'(result_valid_o), 64'h0);
    check("rst_mult_op", 64'(u_if.mult_op_o), 64'h0);
    tick();

    run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, stalls, rv, res);
    #1;
    check("mult_stall_cycles", 64'(stalls), 64'd5);
    check("mult_no_rv", 64'(rv), 64'h0);
    check("mult_hilo", hilo_o, 64'hFFFF_FFFF_FFFF_FFFA);

    run_op(OP_MTHI, 32'h1, 32'h0, stalls, rv, res);
    check("mthi_stall", 64'(stalls), 64'd0);
    run_op(OP_MTLO, 32'h0, 32'h0, stalls, rv, res);
    #1;
    check("mtlo_hilo", hilo_o, 64'h0000_0001_0000_0000);

    run_op(OP_MSUBU, 32'd1, 32'd1, stalls, rv, res);
    #1;
    check("msubu_hilo", hilo_o, 64'h0000_0000_FFFF_FFFF);

    run_op(OP_MADD, 32'd2, 32'd3, stalls, rv, res);
    #1;
    check("madd_hilo", hilo_o, 64'h0000_0001_0000_0005);

    run_op(OP_MUL, 32'd7, 32'd6, stalls, rv, res);
    #1;
    check("mul_rv", 64'(rv), 64'h1);
    check("mul_result", 64'(res), 64'd42);
    check("mul_rv_pulse", 64'(result_valid_o), 64'h0);
    check("mul_hilo_kept", hilo_o, 64'h0000_0001_0000_0005);

    run_op(OP_DIVU, 32'd100, 32'd7, stalls, rv, res);
    #1;
    check("divu_hilo", hilo_o, 64'h0000_0002_0000_000E);

    // Flush in the second BUSY cycle of a DIVU.
    req_valid = 1'b1;
    req_op = OP_DIVU;
    src_a = 32'd50;
    src_b = 32'd7;
    #1;
    check("flush_launch_stall", 64'(stall_o), 64'h1);
    tick();
    check("flush_busy1", 64'(state_o), 64'(BUSY));
    check("flush_div_op", 64'(u_if.div_op_o), 64'h1);
    check("flush_unit_a", 64'(u_if.unit_a_o), 64'd50);
    tick();
    flush_i = 1'b1;
    #1;
    check("flush_stall_low", 64'(stall_o), 64'h0);
    tick();
    flush_i = 1'b0;
    req_valid = 1'b0;
    #1;
    check("flush_drain", 64'(state_o), 64'(DRAIN));
    n = 0;
    while (state_o != IDLE && n < 50) begin
      tick();
      n++;
    end
    check("flush_back_idle", 64'(state_o), 64'(IDLE));
    check("flush_hilo_kept", hilo_o, 64'h0000_0002_0000_000E);
    hilo_read_i = 1'b1;
    #1;
    check("flush_mfhi_stall", 64'(stall_o), 64'h0);
    check("flush_mfhi_hi", 64'(hilo_o[63:32]), 64'h2);
    tick();
    hilo_read_i = 1'b0;

    // Flush in IDLE blocks both an MDU launch and an MTHI write.
    req_valid = 1'b1;
    req_op = OP_MULT;
    flush_i = 1'b1;
    #1;
    check("idle_flush_stall", 64'(stall_o), 64'h0);
    tick();
    check("idle_flush_no_launch", 64'(state_o), 64'(IDLE));
    req_op = OP_MTHI;
    src_a = 32'h1234_5678;
    tick();
    flush_i = 1'b0;
    req_valid = 1'b0;
    #1;
    check("idle_flush_no_mthi", hilo_o, 64'h0000_0002_0000_000E);

    // Watchdog: the multiplier never finishes within TIMEOUT.
    m_lat = 1000;
    req_valid = 1'b1;
    req_op = OP_MULT;
    src_a = 32'd5;
    src_b = 32'd5;
    tick();
    n = 0;
    while (state_o != IDLE && n < 300) begin
      tick();
      n++;
    end
    req_valid = 1'b0;
    #1;
    check("wdog_cycles", 64'(n), 64'd64);
    check("wdog_err", 64'(err_o), 64'h1);
    check("wdog_idle", 64'(state_o), 64'(IDLE));
    check("wdog_hilo_kept", hilo_o, 64'h0000_0002_0000_000E);
    tick();
    check("wdog_err_sticky", 64'(err_o), 64'h1);

    // MTHI then MFHI the next cycle.
    req_valid = 1'b1;
    req_op = OP_MTHI;
    src_a = 32'hDEAD_BEEF;
    #1;
    check("mthi_stall0", 64'(stall_o), 64'h0);
    tick();
    req_valid = 1'b0;
    req_op = 6'h0;
    hilo_read_i = 1'b1;
    #1;
    check("mfhi_stall0", 64'(stall_o), 64'h0);
    check("mfhi_hi", 64'(hilo_o[63:32]), 64'hDEAD_BEEF);
    check("mfhi_hilo", hilo_o, 64'hDEAD_BEEF_0000_000E);
    tick();
    hilo_read_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
